// File: rtl/ntt_loader_if.sv
// rtl/ntt_loader_if.sv - coefficient stream and processor load-port bundle for ntt_loader
//
// Signals:
//   s_valid/s_ready/s_data/s_last  upstream packed-coefficient stream
//   ntt_write_enable/ntt_address/ntt_data  processor core-memory write port
//   ntt_start (to processor), ntt_done (from processor, level)
// Modports:
//   slave  - the loader side (consumes the stream, drives the processor port)
//   master - the environment side (upstream source plus processor model)
interface ntt_loader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 60
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  ntt_write_enable;
    logic [ADDR_WIDTH-1:0] ntt_address;
    logic [DATA_WIDTH-1:0] ntt_data;
    logic                  ntt_start;
    logic                  ntt_done;

    modport slave (
        input  s_valid, s_data, s_last, ntt_done,
        output s_ready, ntt_write_enable, ntt_address, ntt_data, ntt_start
    );

    modport master (
        output s_valid, s_data, s_last, ntt_done,
        input  s_ready, ntt_write_enable, ntt_address, ntt_data, ntt_start
    );
endinterface

// File: rtl/ntt_loader.sv
// rtl/ntt_loader.sv - loads one polynomial frame into the NTT processor, starts it and waits for done
//
// Parameters:
//   ADDR_WIDTH     processor load-address width; a frame is 2^ADDR_WIDTH words
//   DATA_WIDTH     packed word width (two coefficients)
//   SETTLE_CYCLES  idle cycles between the last write and the start pulse (1..15)
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   bus            ntt_loader_if.slave: stream in, processor write/start/done
//   busy           high whenever the FSM is not IDLE
//   frame_done     one-cycle pulse when the transform completes
//   load_error     sticky framing-error flag, cleared by the first beat of a new frame
//   run_cycles     (only with NTT_LOADER_CYCLE_COUNT_EN) saturating ARM+RUN cycle count
// Optional feature macro: NTT_LOADER_CYCLE_COUNT_EN
module ntt_loader #(
    parameter int ADDR_WIDTH    = 11,
    parameter int DATA_WIDTH    = 60,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    ntt_loader_if.slave bus,
    output logic busy,
    output logic frame_done,
    output logic load_error
`ifdef NTT_LOADER_CYCLE_COUNT_EN
    ,
    output logic [31:0] run_cycles
`endif
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        START,
        ARM,
        RUN,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t                state;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [3:0]            settle_cnt;
    logic                  ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  start_q;
    logic                  frame_done_q;
    logic                  load_error_q;
    logic                  hs;

    // ready_q is only ever set while in IDLE/LOAD, so a handshake implies one of those states.
    assign hs = bus.s_valid && ready_q;

    assign bus.s_ready          = ready_q;
    assign bus.ntt_write_enable = wr_en_q;
    assign bus.ntt_address      = wr_addr_q;
    assign bus.ntt_data         = wr_data_q;
    assign bus.ntt_start        = start_q;
    assign busy                 = (state != IDLE);
    assign frame_done           = frame_done_q;
    assign load_error           = load_error_q;

`ifdef NTT_LOADER_CYCLE_COUNT_EN
    logic [31:0] run_cnt_q;
    assign run_cycles = run_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            word_cnt     <= '0;
            settle_cnt   <= '0;
            ready_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            load_error_q <= 1'b0;
`ifdef NTT_LOADER_CYCLE_COUNT_EN
            run_cnt_q    <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle echo of the handshake; address/data hold otherwise.
            wr_en_q <= 1'b0;

            case (state)
                IDLE, LOAD: begin
                    ready_q <= 1'b1;
                    if (hs) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= word_cnt;
                        wr_data_q <= bus.s_data;
                        if (word_cnt == LAST_ADDR) begin
                            // Full frame: a missing s_last is flagged but the frame is still run.
                            state      <= SETTLE;
                            ready_q    <= 1'b0;
                            word_cnt   <= '0;
                            settle_cnt <= '0;
                            if (!bus.s_last) begin
                                load_error_q <= 1'b1;
                            end
                        end else if (bus.s_last) begin
                            // Short frame: the word is written, but the frame is dropped.
                            load_error_q <= 1'b1;
                            state        <= IDLE;
                            word_cnt     <= '0;
                        end else begin
                            if (state == IDLE) begin
                                load_error_q <= 1'b0;
                            end
                            state    <= LOAD;
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end

                SETTLE: begin
                    // First SETTLE cycle carries the final write; then SETTLE_CYCLES quiet cycles.
                    if (settle_cnt == SETTLE_LAST) begin
                        state   <= START;
                        start_q <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                START: begin
                    start_q <= 1'b0;
                    state   <= ARM;
`ifdef NTT_LOADER_CYCLE_COUNT_EN
                    run_cnt_q <= '0;
`endif
                end

                ARM: begin
                    // done is still the previous run's level here; ignore it.
                    state <= RUN;
`ifdef NTT_LOADER_CYCLE_COUNT_EN
                    if (run_cnt_q != 32'hFFFF_FFFF) begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
`endif
                end

                RUN: begin
`ifdef NTT_LOADER_CYCLE_COUNT_EN
                    if (run_cnt_q != 32'hFFFF_FFFF) begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
`endif
                    if (bus.ntt_done) begin
                        state        <= FINISH;
                        frame_done_q <= 1'b1;
                    end
                end

                FINISH: begin
                    frame_done_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_loader.sv
// tb/tb_ntt_loader.sv - directed self-checking bench for ntt_loader
module tb_ntt_loader;
    localparam int AW = 11;
    localparam int DW = 60;
    localparam int SC = 2;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic frame_done;
    logic load_error;
`ifdef NTT_LOADER_CYCLE_COUNT_EN
    logic [31:0] run_cycles;
`endif

    ntt_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ntt_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .busy(busy),
        .frame_done(frame_done),
        .load_error(load_error)
`ifdef NTT_LOADER_CYCLE_COUNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i);
        word = {30'(32'(i) ^ 32'h2AAA_AAAA), 30'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words (index = address), s_last on word last_at; checks every write echo.
    task automatic stream(input int n, input int last_at, input bit random_valid,
                          output int wr_err, output logic le_first);
        int sent = 0;
        int budget = 0;
        bit hs;
        wr_err   = 0;
        le_first = 1'bx;
        while (sent < n && budget < 8 * n + 100) begin
            bus.s_valid = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data  = word(sent);
            bus.s_last  = (sent == last_at);
            hs = bus.s_valid && bus.s_ready;
            tick();
            budget++;
            if (hs) begin
                if (!(bus.ntt_write_enable === 1'b1 && bus.ntt_address === AW'(sent)
                      && bus.ntt_data === word(sent))) wr_err++;
                if (sent == 0) le_first = load_error;
                sent++;
            end else if (bus.ntt_write_enable !== 1'b0) begin
                wr_err++;
            end
        end
        wr_err += n - sent;
        bus.s_last = 1'b0;
    endtask

    // Called in the cycle of the final write; returns cycles until ntt_start is seen.
    task automatic wait_start(output int lat, output int rdy_err);
        lat     = 0;
        rdy_err = 0;
        if (bus.s_ready !== 1'b0) rdy_err++;
        while (bus.ntt_start !== 1'b1 && lat < 50) begin
            tick();
            lat++;
            if (bus.s_ready !== 1'b0) rdy_err++;
            if (bus.ntt_write_enable !== 1'b0) rdy_err++;
        end
    endtask

    // Called in the START cycle T; done rises in cycle T+1+rise.
    task automatic finish_run(input string tag, input int rise, input logic [31:0] exp_cycles);
        int bad = 0;
        int cyc;
        tick();
        check({tag, "_start_one_cycle"}, bus.ntt_start, 1'b0);
        tick();
        bus.ntt_done = 1'b0;
        check({tag, "_no_done_in_arm"}, frame_done, 1'b0);
        cyc = 2;
        while (cyc < rise + 1) begin
            tick();
            cyc++;
            if (frame_done !== 1'b0 || bus.s_ready !== 1'b0 || bus.ntt_start !== 1'b0
                || busy !== 1'b1) bad++;
        end
        bus.ntt_done = 1'b1;
        tick();
        check({tag, "_frame_done"}, frame_done, 1'b1);
        check({tag, "_ready_in_finish"}, bus.s_ready, 1'b0);
`ifdef NTT_LOADER_CYCLE_COUNT_EN
        check({tag, "_run_cycles"}, run_cycles, exp_cycles);
`else
        if (exp_cycles == 32'd0) bad++;
`endif
        bus.ntt_done = 1'b0;
        tick();
        check({tag, "_frame_done_width"}, frame_done, 1'b0);
        check({tag, "_idle_after"}, {busy, bus.s_ready}, 2'b01);
`ifdef NTT_LOADER_CYCLE_COUNT_EN
        check({tag, "_run_cycles_hold"}, run_cycles, exp_cycles);
`endif
        check({tag, "_run_phase"}, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {bus.s_ready, bus.ntt_write_enable, bus.ntt_start, busy,
                               frame_done, load_error}, 6'b0);
        check({tag, "_addr"}, bus.ntt_address, '0);
        check({tag, "_data"}, bus.ntt_data, '0);
    endtask

    initial begin
        int   err;
        int   lat;
        int   rerr;
        int   starts;
        logic le;

        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_last   = 1'b0;
        bus.ntt_done = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
`ifdef NTT_LOADER_CYCLE_COUNT_EN
        check("reset_run_cycles", run_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic frame, continuous valid
        stream(N, N - 1, 1'b0, err, le);
        bus.s_valid = 1'b0;
        check("basic_writes", err, 0);
        check("basic_le_first", le, 1'b0);
        wait_start(lat, rerr);
        check("basic_start_latency", lat, SC + 1);
        check("basic_settle_quiet", rerr, 0);
        check("basic_load_error", load_error, 1'b0);
        finish_run("basic", 100, 32'd101);

        // Random gaps, valid held high through RUN, back-to-back second frame
        stream(N, N - 1, 1'b1, err, le);
        check("gaps1_writes", err, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = word(0);
        wait_start(lat, rerr);
        check("gaps1_start_latency", lat, SC + 1);
        check("gaps1_backpressure", rerr, 0);
        finish_run("gaps1", 100, 32'd101);
        bus.ntt_done = 1'b1;
        stream(N, N - 1, 1'b1, err, le);
        bus.s_valid = 1'b0;
        check("gaps2_writes", err, 0);
        // Stale done: high before start, dropped at ARM+1, raised 100 cycles later
        wait_start(lat, rerr);
        check("stale_start_latency", lat, SC + 1);
        check("stale_settle_quiet", rerr, 0);
        finish_run("stale", 101, 32'd102);

        // Early s_last on word 100
        stream(101, 100, 1'b0, err, le);
        bus.s_valid = 1'b0;
        check("early_writes", err, 0);
        check("early_load_error", load_error, 1'b1);
        check("early_idle", busy, 1'b0);
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.ntt_start !== 1'b0 || busy !== 1'b0) starts++;
        end
        check("early_no_start", starts, 0);

        // Missing s_last: error set but frame still runs; first beat cleared the old error
        stream(N, -1, 1'b0, err, le);
        bus.s_valid = 1'b0;
        check("nolast_writes", err, 0);
        check("nolast_le_cleared_first_beat", le, 1'b0);
        wait_start(lat, rerr);
        check("nolast_start_latency", lat, SC + 1);
        check("nolast_load_error", load_error, 1'b1);
        finish_run("nolast", 100, 32'd101);

        // Asynchronous reset at word 500
        stream(500, -1, 1'b0, err, le);
        check("mid_writes", err, 0);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        bus.s_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Clean frame from address 0, then reset during RUN
        stream(N, N - 1, 1'b0, err, le);
        bus.s_valid = 1'b0;
        check("post_reset_writes", err, 0);
        wait_start(lat, rerr);
        check("post_reset_start_latency", lat, SC + 1);
        tick();
        tick();
        tick();
        check("run_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_run");
`ifdef NTT_LOADER_CYCLE_COUNT_EN
        check("reset_in_run_cycles", run_cycles, 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        // Final clean frame
        stream(N, N - 1, 1'b0, err, le);
        bus.s_valid = 1'b0;
        check("final_writes", err, 0);
        wait_start(lat, rerr);
        check("final_start_latency", lat, SC + 1);
        check("final_load_error", load_error, 1'b0);
        finish_run("final", 100, 32'd101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
